multi_image_reconfig_ctrl: RTL and testbench

Parametrised internal-reconfiguration sequencer for multi-image flash. Accepts an image-select request over a valid/ready handshake and drives cfg_ENA, cfg_CBSEL and cfg_CONFIG in a timed sequence. Monitors cfg_ERROR and falls back to the golden image once on error. Sits in the golden/application top between user control logic and the device configuration-control pins.

---
 rtl/multi_image_reconfig_pkg.sv | 22 ++
 rtl/multi_image_reconfig_ctrl_sync.sv | 25 ++
 rtl/multi_image_reconfig_ctrl.sv | 163 ++++++++++++++++
 tb/tb_multi_image_reconfig_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_image_reconfig_pkg.sv
// Shared definitions for the multi-image reconfiguration sequencer:
// FSM state encodings and the sequencing-counter width helper.
package multi_image_reconfig_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SETUP = 3'd1;
    localparam state_t ST_PULSE = 3'd2;
    localparam state_t ST_WAIT  = 3'd3;
    localparam state_t ST_FAIL  = 3'd4;

    // The width must hold the largest terminal count of any phase without wrapping.
    function automatic int cnt_width(input int setup_len, input int pulse_len, input int wait_len);
        int m;
        m = setup_len;
        if (pulse_len > m) m = pulse_len;
        if (wait_len > m) m = wait_len;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/multi_image_reconfig_ctrl_sync.sv
// Two-flop synchroniser for asynchronous configuration-pin inputs,
// cleared by the synchronous active-high reset.
module cfg_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments keep meta and q as two distinct flop stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/multi_image_reconfig_ctrl.sv
// Internal-reconfiguration sequencer: drives cfg_ENA/cfg_CBSEL/cfg_CONFIG in a
// timed sequence and retries the golden image once on error or timeout.
module multi_image_reconfig_ctrl
    import multi_image_reconfig_pkg::*;
#(
    parameter int CBSEL_W      = 2,
    parameter int NUM_IMAGES   = 4,
    parameter int GOLDEN_IMAGE = 0,
    parameter int ENA_SETUP    = 16,
    parameter int CONFIG_PULSE = 8,
    parameter int WAIT_TIMEOUT = 1024,
    parameter int HB_DIV       = 2**24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [CBSEL_W-1:0] req_image,
    output logic               req_ready,
    output logic               req_reject,
    input  logic               cfg_ERROR,
    output logic               cfg_ENA,
    output logic [CBSEL_W-1:0] cfg_CBSEL,
    output logic               cfg_CONFIG,
    output logic               cfg_ERROR_port,
    output logic               busy,
    output logic               err_sticky,
    output logic               fallback_taken,
    output logic [3:0]         led
);

    localparam int CNT_W = cnt_width(ENA_SETUP, CONFIG_PULSE, WAIT_TIMEOUT);
    localparam int HB_W  = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;

    localparam logic [CNT_W-1:0]   SETUP_LAST = CNT_W'(ENA_SETUP);
    localparam logic [CNT_W-1:0]   PULSE_LAST = CNT_W'(CONFIG_PULSE - 1);
    localparam logic [CNT_W-1:0]   WAIT_LAST  = CNT_W'(WAIT_TIMEOUT - 1);
    localparam logic [HB_W-1:0]    HB_LAST    = HB_W'(HB_DIV - 1);
    localparam logic [CBSEL_W-1:0] GOLDEN     = CBSEL_W'(GOLDEN_IMAGE);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CBSEL_W-1:0] cbsel;
    logic               err;
    logic               sticky;
    logic               fb;
    logic               reject;
    logic [HB_W-1:0]    hb_cnt;
    logic               hb;

    logic        active;
    logic        accept;
    logic        image_bad;
    logic        wait_expired;
    logic        err_event;
    logic        can_fallback;
    logic [31:0] req_idx;

    cfg_sync2 #(.WIDTH(1)) u_err_sync (
        .clk (clk),
        .rst (rst),
        .d   (cfg_ERROR),
        .q   (err)
    );

    // Widen before comparing so a full-range NUM_IMAGES is not a constant compare.
    assign req_idx      = 32'(req_image);
    assign image_bad    = req_idx >= 32'(NUM_IMAGES);
    assign active       = (state == ST_SETUP) || (state == ST_PULSE) || (state == ST_WAIT);
    assign accept       = req_valid && (state == ST_IDLE);
    assign wait_expired = (state == ST_WAIT) && (cnt == WAIT_LAST);
    // A synchronised error and a timeout in the same cycle form one event.
    assign err_event    = active && (err || wait_expired);
    assign can_fallback = (cbsel != GOLDEN) && !fb;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            cbsel  <= GOLDEN;
            sticky <= 1'b0;
            fb     <= 1'b0;
            reject <= 1'b0;
        end else begin
            reject <= accept && image_bad;
            if (err_event) begin
                sticky <= 1'b1;
                cnt    <= '0;
                cbsel  <= GOLDEN;
                if (can_fallback) begin
                    fb    <= 1'b1;
                    state <= ST_SETUP;
                end else begin
                    state <= ST_FAIL;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            if (image_bad) begin
                                sticky <= 1'b1;
                            end else begin
                                cbsel <= req_image;
                                cnt   <= '0;
                                state <= ST_SETUP;
                            end
                        end
                    end
                    // SETUP spans ENA_SETUP+1 cycles so CONFIG rises ENA_SETUP+1 cycles after accept.
                    ST_SETUP: begin
                        if (cnt == SETUP_LAST) begin
                            cnt   <= '0;
                            state <= ST_PULSE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_PULSE: begin
                        if (cnt == PULSE_LAST) begin
                            cnt   <= '0;
                            state <= ST_WAIT;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_WAIT: begin
                        if (cnt != WAIT_LAST) cnt <= cnt + CNT_W'(1);
                    end
                    ST_FAIL: begin
                        state <= ST_FAIL;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hb_cnt <= '0;
            hb     <= 1'b0;
        end else if (hb_cnt == HB_LAST) begin
            hb_cnt <= '0;
            hb     <= ~hb;
        end else begin
            hb_cnt <= hb_cnt + HB_W'(1);
        end
    end

    // Outputs decode directly from state so a reset edge clears them in the same cycle.
    assign req_ready      = (state == ST_IDLE);
    assign req_reject     = reject;
    assign cfg_ENA        = active;
    assign cfg_CONFIG     = (state == ST_PULSE);
    assign cfg_CBSEL      = cbsel;
    assign cfg_ERROR_port = err;
    assign busy           = active;
    assign err_sticky     = sticky;
    assign fallback_taken = fb;
    assign led            = {fb, sticky, active, hb};

endmodule

// File: tb/tb_multi_image_reconfig_ctrl.sv
// Self-checking bench: table of request scenarios with a per-cycle expectation
// scoreboard, plus hand-written sequences for reject, sync latency, reset and heartbeat.
module tb_multi_image_reconfig_ctrl;

    localparam int CBSEL_W = 2;
    localparam int NUM_IMG = 3;
    localparam int GOLD    = 0;
    localparam int S       = 16;
    localparam int P       = 8;
    localparam int W       = 64;
    localparam int HB      = 8;
    localparam int RUN_LEN = 190;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req_valid = 1'b0;
    logic [CBSEL_W-1:0] req_image = '0;
    logic               req_ready;
    logic               req_reject;
    logic               cfg_ERROR = 1'b0;
    logic               cfg_ENA;
    logic [CBSEL_W-1:0] cfg_CBSEL;
    logic               cfg_CONFIG;
    logic               cfg_ERROR_port;
    logic               busy;
    logic               err_sticky;
    logic               fallback_taken;
    logic [3:0]         led;

    multi_image_reconfig_ctrl #(
        .CBSEL_W      (CBSEL_W),
        .NUM_IMAGES   (NUM_IMG),
        .GOLDEN_IMAGE (GOLD),
        .ENA_SETUP    (S),
        .CONFIG_PULSE (P),
        .WAIT_TIMEOUT (W),
        .HB_DIV       (HB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_image      (req_image),
        .req_ready      (req_ready),
        .req_reject     (req_reject),
        .cfg_ERROR      (cfg_ERROR),
        .cfg_ENA        (cfg_ENA),
        .cfg_CBSEL      (cfg_CBSEL),
        .cfg_CONFIG     (cfg_CONFIG),
        .cfg_ERROR_port (cfg_ERROR_port),
        .busy           (busy),
        .err_sticky     (err_sticky),
        .fallback_taken (fallback_taken),
        .led            (led)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic               ready;
        logic               reject;
        logic               ena;
        logic               trig;
        logic [CBSEL_W-1:0] cbsel;
        logic               busy;
        logic               sticky;
        logic               fb;
        logic [2:0]         led_hi;
    } obs_t;

    typedef struct {
        obs_t  exp;
        string name;
    } sb_entry_t;

    typedef struct {
        string              name;
        logic [CBSEL_W-1:0] img;
        int                 err_n;
    } scen_t;

    sb_entry_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic obs_t mk(input logic ready, input logic reject, input logic ena,
                                input logic trig, input logic [CBSEL_W-1:0] cbsel,
                                input logic bsy, input logic st, input logic fb);
        obs_t o;
        o.ready  = ready;
        o.reject = reject;
        o.ena    = ena;
        o.trig   = trig;
        o.cbsel  = cbsel;
        o.busy   = bsy;
        o.sticky = st;
        o.fb     = fb;
        o.led_hi = {fb, st, bsy};
        return o;
    endfunction

    function automatic obs_t get_obs();
        obs_t o;
        o.ready  = req_ready;
        o.reject = req_reject;
        o.ena    = cfg_ENA;
        o.trig   = cfg_CONFIG;
        o.cbsel  = cfg_CBSEL;
        o.busy   = busy;
        o.sticky = err_sticky;
        o.fb     = fallback_taken;
        o.led_hi = led[3:1];
        return o;
    endfunction

    // Scoreboard consumer: compares one expected record per cycle away from the active edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_entry_t e;
            e = sb.pop_front();
            check(e.name, 32'(get_obs()), 32'(e.exp));
        end
    end

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        cfg_ERROR = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Expected timeline: each segment is SETUP (rel 0..S), PULSE (S+1..S+P), WAIT (..S+P+W);
    // an error event restarts a golden segment once, otherwise FAIL.
    task automatic run_scen(input scen_t sc, input bit with_rst);
        int seg = 0;
        int rel;
        bit fb = 1'b0;
        bit st = 1'b0;
        bit failed = 1'b0;
        logic [CBSEL_W-1:0] cur;
        sb_entry_t e;
        if (with_rst) do_reset();
        cur       = sc.img;
        req_valid = 1'b1;
        req_image = sc.img;
        for (int t = 0; t < RUN_LEN; t++) begin
            @(posedge clk);
            if (t > 0 && !failed) begin
                rel = t - seg;
                if ((sc.err_n >= 0 && t == sc.err_n + 3) || rel == S + P + W + 1) begin
                    st = 1'b1;
                    if (cur != CBSEL_W'(GOLD) && !fb) begin
                        fb  = 1'b1;
                        cur = CBSEL_W'(GOLD);
                        seg = t;
                    end else begin
                        failed = 1'b1;
                        cur    = CBSEL_W'(GOLD);
                    end
                end
            end
            rel = t - seg;
            if (failed)
                e.exp = mk(1'b0, 1'b0, 1'b0, 1'b0, CBSEL_W'(GOLD), 1'b0, st, fb);
            else
                e.exp = mk(1'b0, 1'b0, 1'b1, (rel >= S + 1 && rel <= S + P), cur, 1'b1, st, fb);
            e.name = $sformatf("%s t=%0d", sc.name, t);
            sb.push_back(e);
            #1;
            req_valid = 1'b0;
            cfg_ERROR = (t == sc.err_n);
        end
        cfg_ERROR = 1'b0;
        repeat (2) @(negedge clk);
        check({sc.name, " sb_drained"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        scen_t scen [4];
        scen_t after_rst;
        obs_t  rst_obs;
        scen[0] = '{"nominal_img2_timeouts", 2'd2, -1};
        scen[1] = '{"img1_err_in_pulse",     2'd1, S + 2};
        scen[2] = '{"golden_err_in_setup",   2'd0, 5};
        scen[3] = '{"img1_timeouts",         2'd1, -1};
        after_rst = '{"img1_after_rst", 2'd1, -1};
        rst_obs = mk(1'b1, 1'b0, 1'b0, 1'b0, CBSEL_W'(GOLD), 1'b0, 1'b0, 1'b0);

        // Reset state and heartbeat cadence.
        do_reset();
        check("reset_outputs", 32'(get_obs()), 32'(rst_obs));
        check("reset_led", 32'(led), 32'd0);
        check("reset_err_port", 32'(cfg_ERROR_port), 32'd0);
        repeat (HB - 1) @(posedge clk);
        #1 check("hb_before_toggle", 32'(led[0]), 32'd0);
        @(posedge clk);
        #1 check("hb_after_toggle", 32'(led[0]), 32'd1);

        // Out-of-range request: one-cycle reject, sticky error, stays idle.
        do_reset();
        req_valid = 1'b1;
        req_image = 2'd3;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("reject_pulse", 32'(get_obs()),
              32'(mk(1'b1, 1'b1, 1'b0, 1'b0, CBSEL_W'(GOLD), 1'b0, 1'b1, 1'b0)));
        @(posedge clk);
        #1 check("reject_after", 32'(get_obs()),
                 32'(mk(1'b1, 1'b0, 1'b0, 1'b0, CBSEL_W'(GOLD), 1'b0, 1'b1, 1'b0)));

        // Synchroniser latency with the error ignored in IDLE.
        do_reset();
        cfg_ERROR = 1'b1;
        @(posedge clk);
        #1 check("sync_stage1", 32'(cfg_ERROR_port), 32'd0);
        @(posedge clk);
        #1 check("sync_stage2", 32'(cfg_ERROR_port), 32'd1);
        check("idle_ignores_err", 32'(get_obs()), 32'(rst_obs));
        cfg_ERROR = 1'b0;

        for (int i = 0; i < 4; i++) run_scen(scen[i], 1'b1);

        // Reset in the middle of the pulse aborts at once; a new request then runs normally.
        do_reset();
        req_valid = 1'b1;
        req_image = 2'd1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (S + 3) @(posedge clk);
        #1 check("pulse_before_rst", 32'(cfg_CONFIG), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 check("rst_mid_pulse", 32'(get_obs()), 32'(rst_obs));
        check("rst_mid_pulse_led", 32'(led), 32'd0);
        rst = 1'b0;
        run_scen(after_rst, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
